// File: rtl/spc_stack.sv
// ---------------------------------------------------------------------------
// spc_stack -- 32-entry x 19-bit return-PC stack.
//
// Each entry holds a 14-bit return PC in [13:0] and five flag bits in [18:14].
// The top of stack is read combinationally from the entry the pointer selects.
// Every operation completes in a single cycle, and the stack never stalls.
//
// Handshake: state_fetch acts as the "valid" strobe for spush and spop.
// There is no ready signal because the stack accepts every strobed
// operation on the same rising edge. When state_fetch is low, spush and
// spop have no effect.
//
// Optional feature: define SPC_DEPTH_CHECK_EN to build in a 0..32 depth
// counter and the sticky overflow/underflow flags. Without it, both flags
// are tied to 0 and spc_err_clr is ignored.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   state_fetch  in   operation strobe
//   spush        in   push request
//   spop         in   pop request (push+pop together = replace top)
//   spcw[18:0]   in   write data
//   spco[18:0]   out  current top-of-stack entry (mem[spcptr])
//   spcptr[4:0]  out  current stack pointer
//   spc_ovf      out  sticky overflow flag
//   spc_unf      out  sticky underflow flag
//   spc_err_clr  in   clears both sticky flags
// ---------------------------------------------------------------------------
module spc_stack (
    input  logic        clk,
    input  logic        reset,
    input  logic        state_fetch,
    input  logic        spush,
    input  logic        spop,
    input  logic [18:0] spcw,
    output logic [18:0] spco,
    output logic [4:0]  spcptr,
    output logic        spc_ovf,
    output logic        spc_unf,
    input  logic        spc_err_clr
);

    logic [18:0] r_mem [0:31];
    logic [4:0]  r_ptr;

    logic        w_push;
    logic        w_pop;
    logic        w_repl;
    logic        w_wr_en;
    logic [4:0]  w_wr_addr;
    logic [4:0]  w_ptr_inc;
    logic [4:0]  w_ptr_dec;

    assign w_push    = state_fetch & spush & ~spop;
    assign w_pop     = state_fetch & spop & ~spush;
    assign w_repl    = state_fetch & spush & spop;

    // The 5-bit adds wrap naturally, which gives modulo-32 pointer movement.
    assign w_ptr_inc = r_ptr + 5'd1;
    assign w_ptr_dec = r_ptr - 5'd1;

    // A push writes the slot above the current top. A replace overwrites
    // the current top in place.
    assign w_wr_en   = w_push | w_repl;
    assign w_wr_addr = w_repl ? r_ptr : w_ptr_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= 19'd0;
            end
            r_ptr <= 5'd0;
        end else begin
            if (w_wr_en) begin
                r_mem[w_wr_addr] <= spcw;
            end
            if (w_push) begin
                r_ptr <= w_ptr_inc;
            end else if (w_pop) begin
                r_ptr <= w_ptr_dec;
            end
        end
    end

    // The read has no latency. A write on this edge therefore becomes
    // visible in the following cycle.
    assign spco   = r_mem[r_ptr];
    assign spcptr = r_ptr;

`ifdef SPC_DEPTH_CHECK_EN
    logic [5:0] r_depth;
    logic       r_ovf;
    logic       r_unf;
    logic       w_depth_full;
    logic       w_depth_empty;

    assign w_depth_full  = (r_depth == 6'd32);
    assign w_depth_empty = (r_depth == 6'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_depth <= 6'd0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_push && !w_depth_full) begin
                r_depth <= r_depth + 6'd1;
            end else if (w_pop && !w_depth_empty) begin
                r_depth <= r_depth - 6'd1;
            end

            // The clear is applied first, so a set event in the same cycle wins.
            if (spc_err_clr) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end
            if (w_push && w_depth_full) begin
                r_ovf <= 1'b1;
            end
            if (w_pop && w_depth_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign spc_ovf = r_ovf;
    assign spc_unf = r_unf;
`else
    // Depth checking is not built in, so the clear input has no function.
    logic w_unused_err_clr;
    assign w_unused_err_clr = spc_err_clr;

    assign spc_ovf = 1'b0;
    assign spc_unf = 1'b0;
`endif

endmodule

// File: tb/tb_spc_stack.sv
// ---------------------------------------------------------------------------
// tb_spc_stack -- self-checking bench for spc_stack.
// It runs directed scenarios and then randomized operations, and checks the
// results against a behavioural stack model built on an array and modular
// integer arithmetic. Flag expectations follow SPC_DEPTH_CHECK_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spc_stack;

    logic        clk;
    logic        reset;
    logic        state_fetch;
    logic        spush;
    logic        spop;
    logic [18:0] spcw;
    logic [18:0] spco;
    logic [4:0]  spcptr;
    logic        spc_ovf;
    logic        spc_unf;
    logic        spc_err_clr;

    int n_checks;
    int n_fails;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    spc_stack dut (
        .clk         (clk),
        .reset       (reset),
        .state_fetch (state_fetch),
        .spush       (spush),
        .spop        (spop),
        .spcw        (spcw),
        .spco        (spco),
        .spcptr      (spcptr),
        .spc_ovf     (spc_ovf),
        .spc_unf     (spc_unf),
        .spc_err_clr (spc_err_clr)
    );

    // ---------------- reference model ----------------
    logic [18:0] m_mem [32];
    int          m_ptr;
    int          m_depth;
    bit          m_ovf;
    bit          m_unf;
    bit          m_check_en;

    task automatic model_step(input bit rst, input bit sf, input bit pu,
                              input bit po, input bit clr,
                              input logic [18:0] d);
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_ptr   = 0;
            m_depth = 0;
            m_ovf   = 0;
            m_unf   = 0;
            return;
        end
        if (m_check_en && clr) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (!sf) return;
        if (pu && po) begin
            m_mem[m_ptr] = d;
        end else if (pu) begin
            m_ptr = (m_ptr + 1) % 32;
            m_mem[m_ptr] = d;
            if (m_depth == 32) begin
                if (m_check_en) m_ovf = 1;
            end else begin
                m_depth++;
            end
        end else if (po) begin
            m_ptr = (m_ptr + 31) % 32;
            if (m_depth == 0) begin
                if (m_check_en) m_unf = 1;
            end else begin
                m_depth--;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [18:0] got,
                         input logic [18:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [18:0] exp_q[$];

    task automatic compare_outputs(input string ctx);
        logic [18:0] e;
        exp_q.push_back(m_mem[m_ptr]);
        exp_q.push_back(19'(m_ptr));
        exp_q.push_back(19'(m_ovf));
        exp_q.push_back(19'(m_unf));
        e = exp_q.pop_front(); check({ctx, "_spco"},   spco, e);
        e = exp_q.pop_front(); check({ctx, "_spcptr"}, 19'(spcptr), e);
        e = exp_q.pop_front(); check({ctx, "_ovf"},    19'(spc_ovf), e);
        e = exp_q.pop_front(); check({ctx, "_unf"},    19'(spc_unf), e);
    endtask

    // ---------------- driver ----------------
    // Drive inputs, take one rising edge, update the model, then sample 1ns later.
    task automatic step(input string ctx, input bit rst, input bit sf,
                        input bit pu, input bit po, input bit clr,
                        input logic [18:0] d);
        reset       = rst;
        state_fetch = sf;
        spush       = pu;
        spop        = po;
        spc_err_clr = clr;
        spcw        = d;
        @(posedge clk);
        model_step(rst, sf, pu, po, clr, d);
        #1;
        compare_outputs(ctx);
    endtask

    task automatic do_reset(input string ctx);
        step(ctx, 1, 0, 0, 0, 0, 19'd0);
    endtask

    task automatic push(input string ctx, input logic [18:0] d);
        step(ctx, 0, 1, 1, 0, 0, d);
    endtask

    task automatic pop(input string ctx);
        step(ctx, 0, 1, 0, 1, 0, 19'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit rr, sf, pu, po, cl;
        n_checks = 0;
        n_fails  = 0;
`ifdef SPC_DEPTH_CHECK_EN
        m_check_en = 1;
`else
        m_check_en = 0;
`endif
        foreach (m_mem[i]) m_mem[i] = '0;
        m_ptr = 0; m_depth = 0; m_ovf = 0; m_unf = 0;
        reset = 1; state_fetch = 0; spush = 0; spop = 0; spc_err_clr = 0; spcw = '0;

        // Reset state
        do_reset("rst");
        check("rst_ptr0", 19'(spcptr), 19'd0);
        check("rst_spco0", spco, 19'd0);

        // Single push
        push("p1", 19'h00123);
        check("p1_ptr", 19'(spcptr), 19'd1);
        check("p1_spco", spco, 19'h00123);

        // Push, push, pop, then an unstrobed push
        do_reset("rst");
        push("pp", 19'h00010);
        push("pp", 19'h00020);
        pop("pp_pop");
        check("pop_ptr", 19'(spcptr), 19'd1);
        check("pop_spco", spco, 19'h00010);
        step("nofetch", 0, 0, 1, 0, 0, 19'h12345);
        check("nofetch_ptr", 19'(spcptr), 19'd1);
        check("nofetch_spco", spco, 19'h00010);

        // Replace the top; the entry below is left intact
        do_reset("rst");
        push("rp", 19'h00111);
        push("rp", 19'h00222);
        push("rp", 19'h00AAA);
        step("repl", 0, 1, 1, 1, 0, 19'h7FFFF);
        check("repl_ptr", 19'(spcptr), 19'd3);
        check("repl_spco", spco, 19'h7FFFF);
        pop("repl_pop");
        check("repl_below", spco, 19'h00222);

        // 33 pushes wrap the pointer; overflow on the 33rd
        do_reset("rst");
        for (int i = 1; i <= 33; i++) push("wrap", 19'(i));
        check("wrap_ptr", 19'(spcptr), 19'd1);
        check("wrap_spco", spco, 19'd33);
`ifdef SPC_DEPTH_CHECK_EN
        check("wrap_ovf", 19'(spc_ovf), 19'd1);
`else
        check("wrap_ovf", 19'(spc_ovf), 19'd0);
`endif
        pop("wrap_pop");
        check("wrap_e0", spco, 19'd32);

        // Pop from empty, then clear the sticky flag
        do_reset("rst");
        pop("unf");
        check("unf_ptr", 19'(spcptr), 19'd31);
        check("unf_spco", spco, 19'd0);
`ifdef SPC_DEPTH_CHECK_EN
        check("unf_flag", 19'(spc_unf), 19'd1);
`else
        check("unf_flag", 19'(spc_unf), 19'd0);
`endif
        step("clr", 0, 0, 0, 0, 1, 19'd0);
        check("clr_unf", 19'(spc_unf), 19'd0);

        // Reset wins over a simultaneous push
        push("pre", 19'h00999);
        step("rst_push", 1, 1, 1, 0, 0, 19'h00055);
        check("rstp_ptr", 19'(spcptr), 19'd0);
        check("rstp_spco", spco, 19'd0);
        for (int i = 0; i < 31; i++) pop("walk");
        check("rstp_e1_ptr", 19'(spcptr), 19'd1);
        check("rstp_e1", spco, 19'd0);

        // Randomized operations
        do_reset("rst");
        for (int n = 0; n < 1500; n++) begin
            rr = ($urandom_range(0, 199) == 0);
            sf = ($urandom_range(0, 3) != 0);
            pu = $urandom_range(0, 1);
            po = ($urandom_range(0, 2) == 0);
            if (n % 400 > 200) po = ($urandom_range(0, 1) == 1);
            cl = ($urandom_range(0, 15) == 0);
            step("rand", rr, sf, pu, po, cl, 19'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/spc_stack.md
SPC_STACK -- requirements
Module: spc_stack

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: state_fetch  input  1  stack-operation strobe; operations take effect only on cycles where it is high.
REQ-004 SHALL have port: spush  input  1  push request.
REQ-005 SHALL have port: spop  input  1  pop request.
REQ-006 SHALL have port: spcw  input  19  write data; [13:0] return PC (wpc), [18:14] flag bits.
REQ-007 SHALL have port: spco  output  19  current top-of-stack entry.
REQ-008 SHALL have port: spcptr  output  5  current stack pointer.
REQ-009 SHALL have port: spc_ovf  output  1  sticky overflow flag.
REQ-010 SHALL have port: spc_unf  output  1  sticky underflow flag.
REQ-011 SHALL have port: spc_err_clr  input  1  clears both sticky flags.

Function
REQ-012 SHALL hold 32 entries of 19 bits, addressed by the 5-bit pointer.
REQ-013 SHALL drive spco combinationally from mem[spcptr] with no read-port latency.
REQ-014 SHALL ignore spush and spop on cycles where state_fetch is low: pointer and memory unchanged.
REQ-015 On push only (state_fetch=1, spush=1, spop=0), SHALL write mem[spcptr+1] <= spcw and set spcptr <= spcptr+1 on the same edge.
REQ-016 On pop only (state_fetch=1, spop=1, spush=0), SHALL set spcptr <= spcptr-1 and leave memory unchanged.
REQ-017 On simultaneous push and pop (state_fetch=1, both high), SHALL replace the top entry (mem[spcptr] <= spcw) and leave spcptr unchanged.
REQ-018 SHALL perform pointer arithmetic modulo 32: push at 31 wraps to 0; pop at 0 wraps to 31; the wrapped-to entry is overwritten on push.
REQ-019 spco SHALL reflect a push or replace beginning in the cycle after the operating edge; spco in the operating cycle SHALL show the old top.
REQ-020 SHALL complete every operation in one cycle and SHALL never stall or back-pressure.

Reset
REQ-021 On reset, SHALL set spcptr=0, all 32 entries=0, spco=0, spc_ovf=0, spc_unf=0.
REQ-022 SHALL give reset priority over any simultaneous push, pop or spc_err_clr.
REQ-023 On reset asserted mid-sequence, SHALL discard the in-flight operation and show the reset values on the following cycle.

Configuration
REQ-024 SHALL compile depth checking in only when SPC_DEPTH_CHECK_EN is defined.
REQ-025 With SPC_DEPTH_CHECK_EN defined:
- SHALL keep a 6-bit depth counter (0..32), reset to 0.
- Push increments it, saturating at 32; pop decrements it, saturating at 0; replace leaves it unchanged.
- Push at depth 32 SHALL set spc_ovf; pop at depth 0 SHALL set spc_unf.
- Flags stay set until spc_err_clr or reset.
- A set event in the same cycle as spc_err_clr SHALL win.
REQ-026 Without SPC_DEPTH_CHECK_EN:
- No depth counter.
- spc_ovf and spc_unf SHALL be tied to 0; spc_err_clr SHALL be ignored.
- All other behaviour is identical.

Verification
REQ-027 Reset, then push spcw=19'h00123 with state_fetch=1 -> next cycle spcptr=1, spco=19'h00123.
REQ-028 Push 19'h00010 then 19'h00020, then pop -> spcptr=1, spco=19'h00010; spush=1 with state_fetch=0 -> no change.
REQ-029 From spcptr=3, top=19'h00AAA: push+pop with spcw=19'h7FFFF -> spcptr=3, spco=19'h7FFFF, entry 2 intact.
REQ-030 33 pushes of values 1..33 -> spcptr wraps to 1, spco=33, entry 0=32; with macro, spc_ovf=1 after push 33; without macro, spc_ovf=0.
REQ-031 Pop from reset -> spcptr=31, spco=0; with macro, spc_unf=1; then spc_err_clr=1 -> spc_unf=0 next cycle.
REQ-032 Reset asserted in the same cycle as a push of 19'h00055 -> spcptr=0, spco=0, entry 1=0.
